// File: rtl/sr_stack_io_if.sv
// Command and stack-bus handshake between sequencer/bus unit and sr_stack_io.
// The slave modport is the sr_stack_io side; the master modport is the sequencer/bus side.
interface sr_stack_io_if;
   logic       cmd_valid;
   logic [2:0] cmd;
   logic       cmd_ready;
   logic       done;
   logic       bus_wr_en;
   logic [7:0] bus_wr_data;
   logic       bus_rd_req;
   logic [7:0] bus_rd_data;
   logic       bus_ack;

   modport slave (
      input  cmd_valid, cmd, bus_rd_data, bus_ack,
      output cmd_ready, done, bus_wr_en, bus_wr_data, bus_rd_req
   );

   modport master (
      output cmd_valid, cmd, bus_rd_data, bus_ack,
      input  cmd_ready, done, bus_wr_en, bus_wr_data, bus_rd_req
   );
endinterface

// File: rtl/sr_stack_io.sv
// 6502 status register push/pull sequencer with the I-flag set after an interrupt push.
// It also tracks pending interrupts (edge-latched NMI, level IRQ gated by I).
module sr_stack_io #(
   parameter logic [7:0]  PULL_MASK = 8'hCF,
   parameter int unsigned I_BIT     = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sr_in,
   sr_stack_io_if.slave bus,
   output logic [7:0] sr_update_mask,
   output logic [1:0] sr_update_sel,
   output logic [7:0] sr_alu_data,
   input  logic       irq_n,
   input  logic       nmi_n,
   output logic       int_pending,
   output logic       int_is_nmi
);

   localparam logic [2:0] CmdPhp = 3'd0;
   localparam logic [2:0] CmdPlp = 3'd1;
   localparam logic [2:0] CmdBrk = 3'd2;
   localparam logic [2:0] CmdRti = 3'd3;
   localparam logic [2:0] CmdIrq = 3'd4;
   localparam logic [2:0] CmdNmi = 3'd5;

   typedef enum logic [2:0] {StIdle, StPush, StSeti, StPull, StLoad, StDone} state_e;

   state_e     state_q, state_d;
   logic [2:0] cmd_q;
   logic [7:0] data_q;
   logic       nmi_prev_q, nmi_latch_q, nmi_latch_d;
   logic       accept, push_b;
   logic [7:0] i_mask;

   assign accept = bus.cmd_valid && (state_q == StIdle);
   assign i_mask = 8'(1) << I_BIT;
   // B is set only for software pushes (PHP/BRK); hardware interrupts push B=0.
   assign push_b = (cmd_q == CmdPhp) || (cmd_q == CmdBrk);

   // A new falling edge overrides the clear from accepting an NMI in the same cycle.
   assign nmi_latch_d = (nmi_prev_q && !nmi_n) ? 1'b1 :
                        (accept && bus.cmd == CmdNmi) ? 1'b0 : nmi_latch_q;

   assign int_pending = nmi_latch_q | (~irq_n & ~sr_in[I_BIT]);
   assign int_is_nmi  = nmi_latch_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cmd_q       <= 3'd0;
         data_q      <= 8'h00;
         nmi_prev_q  <= 1'b1;
         nmi_latch_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         nmi_prev_q  <= nmi_n;
         nmi_latch_q <= nmi_latch_d;
         if (accept) cmd_q <= bus.cmd;
         if (state_q == StPull && bus.bus_ack) data_q <= bus.bus_rd_data;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               case (bus.cmd)
                  CmdPhp, CmdBrk, CmdIrq, CmdNmi: state_d = StPush;
                  CmdPlp, CmdRti:                 state_d = StPull;
                  default:                        state_d = StDone;
               endcase
            end
         end
         StPush:  if (bus.bus_ack) state_d = (cmd_q == CmdPhp) ? StDone : StSeti;
         StSeti:  state_d = StDone;
         StPull:  if (bus.bus_ack) state_d = StLoad;
         StLoad:  state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.cmd_ready   = 1'b0;
      bus.done        = 1'b0;
      bus.bus_wr_en   = 1'b0;
      bus.bus_wr_data = 8'h00;
      bus.bus_rd_req  = 1'b0;
      sr_update_mask  = 8'h00;
      sr_update_sel   = 2'd0;
      sr_alu_data     = 8'h00;
      unique case (state_q)
         StIdle: bus.cmd_ready = 1'b1;
         StPush: begin
            bus.bus_wr_en   = 1'b1;
            bus.bus_wr_data = {sr_in[7:6], 1'b1, push_b, sr_in[3:0]};
         end
         StSeti: begin
            sr_update_mask = i_mask;
            sr_update_sel  = 2'd1;
         end
         StPull: bus.bus_rd_req = 1'b1;
         StLoad: begin
            sr_update_mask = PULL_MASK;
            sr_update_sel  = 2'd2;
            sr_alu_data    = data_q;
         end
         StDone:  bus.done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_sr_stack_io.sv
// Self-checking bench for sr_stack_io: directed scenarios plus randomized commands and
// interrupt inputs, checked against a transaction-level reference model.
module tb_sr_stack_io;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] sr_in = 8'h00;
   logic [7:0] sr_update_mask;
   logic [1:0] sr_update_sel;
   logic [7:0] sr_alu_data;
   logic       irq_n = 1'b1;
   logic       nmi_n = 1'b1;
   logic       int_pending;
   logic       int_is_nmi;

   int n_tests = 0;
   int n_fail  = 0;

   sr_stack_io_if bus ();

   sr_stack_io dut (
      .clk            (clk),
      .rst            (rst),
      .sr_in          (sr_in),
      .bus            (bus),
      .sr_update_mask (sr_update_mask),
      .sr_update_sel  (sr_update_sel),
      .sr_alu_data    (sr_alu_data),
      .irq_n          (irq_n),
      .nmi_n          (nmi_n),
      .int_pending    (int_pending),
      .int_is_nmi     (int_is_nmi)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      nmi_n = 1'b1;
      irq_n = 1'b1;
      bus.cmd_valid = 1'b0;
      bus.cmd = 3'd0;
      bus.bus_ack = 1'b0;
      bus.bus_rd_data = 8'h00;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Runs one command through the DUT; the model derives every expectation from the
   // command class, the bus wait count and the data involved.
   task automatic run_cmd(input logic [2:0] c, input logic [7:0] sr, input int waits,
                          input logic [7:0] rdata, input bit nmi_fall);
      bit         is_push, is_pull, is_seti;
      logic [7:0] exp_data;
      int         exp_done, done_cyc, k;
      int         wr_cnt, rd_cnt, seti_cnt, load_cnt, bad_data, bad_upd, both, bad_ready;
      is_push  = (c == 3'd0) || (c == 3'd2) || (c == 3'd4) || (c == 3'd5);
      is_pull  = (c == 3'd1) || (c == 3'd3);
      is_seti  = (c == 3'd2) || (c == 3'd4) || (c == 3'd5);
      exp_data = ((sr | 8'h20) & 8'hEF) | (((c == 3'd0) || (c == 3'd2)) ? 8'h10 : 8'h00);
      exp_done = is_push ? waits + 2 + int'(is_seti) : (is_pull ? waits + 3 : 1);
      done_cyc = -1; k = 0;
      wr_cnt = 0; rd_cnt = 0; seti_cnt = 0; load_cnt = 0;
      bad_data = 0; bad_upd = 0; both = 0; bad_ready = 0;

      @(negedge clk);
      check_eq("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
      bus.cmd_valid = 1'b1;
      bus.cmd = c;
      sr_in = sr;
      bus.bus_ack = 1'b0;
      if (nmi_fall) nmi_n = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         bus.cmd = 3'($urandom);  // junk while busy must be ignored
         if (bus.cmd_ready) bad_ready++;
         if (bus.bus_wr_en) begin
            wr_cnt++;
            if (bus.bus_wr_data !== exp_data) bad_data++;
         end
         if (bus.bus_rd_req) rd_cnt++;
         if (bus.bus_wr_en && bus.bus_rd_req) both++;
         if (sr_update_mask != 8'h00) begin
            if (sr_update_mask == 8'h04 && sr_update_sel == 2'd1) seti_cnt++;
            else if (sr_update_mask == 8'hCF && sr_update_sel == 2'd2 && sr_alu_data == rdata)
               load_cnt++;
            else bad_upd++;
         end
         if (bus.bus_wr_en || bus.bus_rd_req) begin
            k++;
            bus.bus_ack = (k == waits + 1);
            bus.bus_rd_data = (k == waits + 1) ? rdata : 8'($urandom);
         end else begin
            bus.bus_ack = 1'b0;
         end
         if (bus.done) begin
            done_cyc = cyc;
            break;
         end
      end
      bus.cmd_valid = 1'b0;
      bus.bus_ack = 1'b0;
      check_eq($sformatf("done_latency_cmd%0d", c), 32'(done_cyc), 32'(exp_done));
      check_eq("wr_cycles", 32'(wr_cnt), is_push ? 32'(waits + 1) : 32'd0);
      check_eq("rd_cycles", 32'(rd_cnt), is_pull ? 32'(waits + 1) : 32'd0);
      check_eq("wr_data", 32'(bad_data), 32'd0);
      check_eq("seti_cycles", 32'(seti_cnt), 32'(is_seti));
      check_eq("load_cycles", 32'(load_cnt), 32'(is_pull));
      check_eq("bad_sr_update", 32'(bad_upd), 32'd0);
      check_eq("wr_rd_overlap", 32'(both), 32'd0);
      check_eq("ready_while_busy", 32'(bad_ready), 32'd0);
      @(negedge clk);
      check_eq("done_one_cycle", 32'(bus.done), 32'd0);
      check_eq("ready_after_done", 32'(bus.cmd_ready), 32'd1);
   endtask

   initial begin
      int bad;
      bit prev_m, latch_m;
      bus.cmd_valid = 1'b0;
      bus.cmd = 3'd0;
      bus.bus_ack = 1'b0;
      bus.bus_rd_data = 8'h00;

      do_reset();
      @(negedge clk);
      check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_eq("rst_outputs", 32'({bus.done, bus.bus_wr_en, bus.bus_rd_req, bus.bus_wr_data,
                                   sr_update_mask, sr_update_sel}), 32'd0);
      check_eq("rst_alu_data", 32'(sr_alu_data), 32'd0);
      check_eq("rst_int", 32'({int_pending, int_is_nmi}), 32'd0);

      // Directed scenarios
      run_cmd(3'd0, 8'hC3, 0, 8'h00, 1'b0);  // PHP -> F3
      run_cmd(3'd4, 8'h81, 0, 8'h00, 1'b0);  // IRQ -> A1, then SETI
      run_cmd(3'd1, 8'h00, 2, 8'hFF, 1'b0);  // PLP with 2 wait cycles
      run_cmd(3'd2, 8'h00, 1, 8'h00, 1'b0);  // BRK from zero
      run_cmd(3'd3, 8'h55, 0, 8'h3A, 1'b0);  // RTI

      // NMI latching, clearing on accept, no re-latch while held low
      bad = 0;
      @(negedge clk);
      nmi_n = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (!(int_pending && int_is_nmi)) bad++;
      end
      check_eq("nmi_latched_10cyc", 32'(bad), 32'd0);
      run_cmd(3'd5, 8'h20, 0, 8'h00, 1'b0);
      check_eq("nmi_cleared_is_nmi", 32'(int_is_nmi), 32'd0);
      check_eq("nmi_cleared_pending", 32'(int_pending), 32'd0);
      repeat (3) @(negedge clk);
      check_eq("nmi_held_no_relatch", 32'(int_is_nmi), 32'd0);
      nmi_n = 1'b1;
      run_cmd(3'd5, 8'h00, 0, 8'h00, 1'b1);  // new fall in the accept cycle: set wins
      check_eq("nmi_set_wins", 32'(int_is_nmi), 32'd1);
      nmi_n = 1'b1;
      run_cmd(3'd5, 8'h00, 0, 8'h00, 1'b0);
      check_eq("nmi_clear_again", 32'(int_is_nmi), 32'd0);

      // IRQ level gating by I
      @(negedge clk);
      irq_n = 1'b0;
      sr_in = 8'h04;
      #1 check_eq("irq_masked", 32'(int_pending), 32'd0);
      @(negedge clk);
      sr_in = 8'h00;
      #1 check_eq("irq_unmasked", 32'(int_pending), 32'd1);
      check_eq("irq_not_nmi", 32'(int_is_nmi), 32'd0);
      @(negedge clk);
      irq_n = 1'b1;
      #1 check_eq("irq_released", 32'(int_pending), 32'd0);

      // Reset in the middle of a pull wait
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd = 3'd1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check_eq("pull_req_before_rst", 32'(bus.bus_rd_req), 32'd1);
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("rst_mid_rd_req", 32'(bus.bus_rd_req), 32'd0);
      check_eq("rst_mid_ready", 32'(bus.cmd_ready), 32'd1);
      check_eq("rst_mid_no_write", 32'(sr_update_mask), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_cmd(3'd7, 8'h00, 0, 8'h00, 1'b0);
      run_cmd(3'd6, 8'hFF, 0, 8'h00, 1'b0);

      // Randomized commands
      for (int i = 0; i < 40; i++)
         run_cmd(3'($urandom_range(0, 7)), 8'($urandom), int'($urandom_range(0, 3)),
                 8'($urandom), 1'b0);

      // Randomized interrupt inputs against an edge/level model
      do_reset();
      prev_m = 1'b1;
      latch_m = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         irq_n = 1'($urandom);
         nmi_n = ($urandom_range(0, 3) != 0);
         sr_in = 8'($urandom);
         #1;
         check_eq("rand_int_is_nmi", 32'(int_is_nmi), 32'(latch_m));
         check_eq("rand_int_pending", 32'(int_pending),
                  32'(latch_m || (!irq_n && !sr_in[2])));
         if (prev_m && !nmi_n) latch_m = 1'b1;
         prev_m = nmi_n;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
